codec_sample_io: RTL and testbench

- Front/back end for the pedal chain; talks to the board audio codec in I2S slave mode, with the codec driving BCLK and LRCK.
- Deserializes ADC samples into a parallel 16-bit word for the pedal chain input, with a one-cycle valid pulse used to START the pedals.
- Serializes the pedal chain's processed output back to the codec DAC.
- All logic runs on the system clock. Codec clocks are oversampled, never used as clocks.

---
 rtl/pedal_pkg.sv | 15 +
 rtl/sync_edge_det.sv | 29 ++
 rtl/codec_sample_io.sv | 223 ++++++++++++++++++++++
 tb/tb_codec_sample_io.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pedal_pkg.sv
// Shared types and constants for the pedal chain codec interface.
package pedal_pkg;

    localparam int SAMPLE_W_C = 16;

    typedef logic signed [SAMPLE_W_C-1:0] sample_t;

    typedef enum logic [1:0] {
        WAIT_LR = 2'd0,
        SKIP    = 2'd1,
        SHIFT   = 2'd2,
        HOLD    = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for a slow external clock-like signal, with
// single-cycle rise and fall pulses in the system clock domain.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/codec_sample_io.sv
// I2S slave front/back end for the pedal chain; codec clocks are oversampled on Clk.
// Build option MONO_SUM_EN: output (L+R)>>>1 after the right word instead of left only.
module codec_sample_io
    import pedal_pkg::*;
#(
    parameter int SAMPLE_W    = SAMPLE_W_C,
    parameter int SYNC_STAGES = 2
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                AUD_BCLK,
    input  logic                AUD_LRCK,
    input  logic                AUD_ADCDAT,
    output logic                AUD_DACDAT,
    output logic [SAMPLE_W-1:0] Sample_out,
    output logic                Sample_valid,
    input  logic [SAMPLE_W-1:0] Sample_in,
    output logic                Frame_err
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);
    localparam int TX_W  = $clog2(SAMPLE_W + 2);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);
    localparam logic [TX_W-1:0]  TX_LAST  = TX_W'(SAMPLE_W);

    logic bclk_rise, bclk_fall;
    logic lr_rise, lr_fall, lr_edge;
    logic [SYNC_STAGES-1:0] adc_sync_q;
    logic adc_bit;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_bclk_det (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .d_i    (AUD_BCLK),
        .rise_o (bclk_rise),
        .fall_o (bclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_lrck_det (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .d_i    (AUD_LRCK),
        .rise_o (lr_rise),
        .fall_o (lr_fall)
    );

    // Same depth as the edge detectors so the data bit lines up with bclk_rise.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            adc_sync_q <= '0;
        end else begin
            adc_sync_q <= {adc_sync_q[SYNC_STAGES-2:0], AUD_ADCDAT};
        end
    end

    assign adc_bit = adc_sync_q[SYNC_STAGES-1];
    assign lr_edge = lr_rise | lr_fall;

    rx_state_t            state_q, state_d;
    logic                 chan_q, chan_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [SAMPLE_W-1:0]  shift_q, shift_d;
    logic [SAMPLE_W-1:0]  word_full;
    logic                 err_q, err_d;
    logic                 word_done;

    assign word_full = {shift_q[SAMPLE_W-2:0], adc_bit};

    // The new channel equals the new LRCK level, which is 1 exactly on a rising edge.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        count_d   = count_q;
        shift_d   = shift_q;
        err_d     = err_q;
        word_done = 1'b0;
        case (state_q)
            WAIT_LR: begin
                if (lr_edge) begin
                    state_d = SKIP;
                    chan_d  = lr_rise;
                end
            end
            SKIP: begin
                if (lr_edge) begin
                    err_d  = 1'b1;
                    chan_d = lr_rise;
                end else if (bclk_rise) begin
                    state_d = SHIFT;
                    count_d = '0;
                end
            end
            SHIFT: begin
                if (lr_edge) begin
                    err_d   = 1'b1;
                    chan_d  = lr_rise;
                    state_d = SKIP;
                    count_d = '0;
                end else if (bclk_rise) begin
                    shift_d = word_full;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_BIT) begin
                        state_d   = HOLD;
                        word_done = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (lr_edge) begin
                    state_d = SKIP;
                    chan_d  = lr_rise;
                end
            end
            default: state_d = WAIT_LR;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= WAIT_LR;
            chan_q  <= 1'b0;
            count_q <= '0;
            shift_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            count_q <= count_d;
            shift_q <= shift_d;
            err_q   <= err_d;
        end
    end

    logic [SAMPLE_W-1:0] sample_q;
    logic                valid_q;

`ifdef MONO_SUM_EN
    logic [SAMPLE_W-1:0]        left_q;
    logic                       left_ok_q;
    logic signed [SAMPLE_W:0]   sum_w;

    assign sum_w = $signed({left_q[SAMPLE_W-1], left_q})
                 + $signed({word_full[SAMPLE_W-1], word_full});

    // A right word only produces output if this frame's left word completed.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sample_q  <= '0;
            valid_q   <= 1'b0;
            left_q    <= '0;
            left_ok_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (lr_fall) begin
                left_ok_q <= 1'b0;
            end
            if (word_done && !chan_q) begin
                left_q    <= word_full;
                left_ok_q <= 1'b1;
            end
            if (word_done && chan_q && left_ok_q) begin
                sample_q  <= SAMPLE_W'(sum_w >>> 1);
                valid_q   <= 1'b1;
                left_ok_q <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (word_done && !chan_q) begin
                sample_q <= word_full;
                valid_q  <= 1'b1;
            end
        end
    end
`endif

    logic [SAMPLE_W-1:0] hold_q;
    logic [SAMPLE_W-1:0] tx_q;
    logic [TX_W-1:0]     tx_cnt_q;
    logic                dac_q;

    // tx_cnt_q == 0 marks the pending I2S delay slot; the reload always wins over bclk_fall.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_q   <= '0;
            tx_q     <= '0;
            tx_cnt_q <= '0;
            dac_q    <= 1'b0;
        end else if (lr_edge) begin
            if (lr_fall) begin
                hold_q <= Sample_in;
                tx_q   <= Sample_in;
            end else begin
                tx_q   <= hold_q;
            end
            tx_cnt_q <= '0;
            dac_q    <= 1'b0;
        end else if (bclk_fall) begin
            if (tx_cnt_q == '0) begin
                dac_q    <= 1'b0;
                tx_cnt_q <= TX_W'(1);
            end else if (tx_cnt_q <= TX_LAST) begin
                dac_q    <= tx_q[SAMPLE_W-1];
                tx_q     <= {tx_q[SAMPLE_W-2:0], 1'b0};
                tx_cnt_q <= tx_cnt_q + TX_W'(1);
            end else begin
                dac_q    <= 1'b0;
            end
        end
    end

    assign Sample_out   = sample_q;
    assign Sample_valid = valid_q;
    assign Frame_err    = err_q;
    assign AUD_DACDAT   = dac_q;

endmodule

// File: tb/tb_codec_sample_io.sv
// Directed bench for codec_sample_io: table of left/right frames plus a mid-word reset.
// Expected values follow MONO_SUM_EN when the macro is defined.
module tb_codec_sample_io;

    localparam int SW = 16;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          AUD_BCLK = 1'b0;
    logic          AUD_LRCK = 1'b0;
    logic          AUD_ADCDAT = 1'b0;
    logic          AUD_DACDAT;
    logic [SW-1:0] Sample_out;
    logic          Sample_valid;
    logic [SW-1:0] Sample_in = '0;
    logic          Frame_err;

    int checks = 0;
    int passes = 0;
    int validCount = 0;
    logic dacCap [0:31];

    codec_sample_io dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_LRCK     (AUD_LRCK),
        .AUD_ADCDAT   (AUD_ADCDAT),
        .AUD_DACDAT   (AUD_DACDAT),
        .Sample_out   (Sample_out),
        .Sample_valid (Sample_valid),
        .Sample_in    (Sample_in),
        .Frame_err    (Frame_err)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Sample_valid) validCount++;
    end

`ifdef MONO_SUM_EN
    localparam logic [SW-1:0] EXP0 = 16'hDBFB;
    localparam logic [SW-1:0] EXP1 = 16'h4919;
    localparam logic [SW-1:0] EXP3 = 16'hC000;
    localparam logic [SW-1:0] EXP4 = 16'h7FFF;
    localparam logic [SW-1:0] EXPR = 16'h0787;
    localparam int LEFT_VALID = 0;
`else
    localparam logic [SW-1:0] EXP0 = 16'hA5C3;
    localparam logic [SW-1:0] EXP1 = 16'h7FFF;
    localparam logic [SW-1:0] EXP3 = 16'h8000;
    localparam logic [SW-1:0] EXP4 = 16'h7FFF;
    localparam logic [SW-1:0] EXPR = 16'h0F0F;
    localparam int LEFT_VALID = 1;
`endif

    typedef struct {
        logic [23:0]   left;
        logic [23:0]   right;
        int            nbits;
        int            leftPeriods;
        logic [SW-1:0] sin;
        logic [SW-1:0] expOut;
        int            expValid;
        logic          expErr;
    } vec_t;

    vec_t vecs [5];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One BCLK period: falling edge with new LRCK/data, DAC sampled just before the rise.
    task automatic bclkPeriod(input logic lr, input logic dat, input int idx);
        @(negedge Clk);
        AUD_BCLK   = 1'b0;
        AUD_LRCK   = lr;
        AUD_ADCDAT = dat;
        repeat (8) @(negedge Clk);
        dacCap[idx] = AUD_DACDAT;
        AUD_BCLK = 1'b1;
        repeat (7) @(negedge Clk);
    endtask

    task automatic applyStimulus(input logic lr, input logic [23:0] word, input int nbits,
                                 input int periods, input logic flipSin);
        for (int i = 0; i < periods; i++) begin
            logic d;
            d = (i >= 1 && i <= nbits) ? word[nbits - i] : 1'b0;
            if (flipSin && i == 5) Sample_in = ~Sample_in;
            bclkPeriod(lr, d, i);
        end
    endtask

    task automatic readDac(output logic [SW-1:0] word, output logic tailZero, input int periods);
        word = '0;
        tailZero = 1'b1;
        for (int p = 0; p < periods; p++) begin
            if (p >= 2 && p <= 17) word[17 - p] = dacCap[p];
            else if (dacCap[p] !== 1'b0) tailZero = 1'b0;
        end
    endtask

    initial begin
        int v0;
        logic [SW-1:0] dacWord;
        logic tailZero;

        vecs[0] = '{24'h00A5C3, 24'h001234, 16, 32, 16'h8001, EXP0, 1, 1'b0};
        vecs[1] = '{24'h7FFF00, 24'h123456, 24, 32, 16'h1234, EXP1, 1, 1'b0};
        vecs[2] = '{24'h0003FF, 24'h005555, 16, 11, 16'h0F0F, EXP1, 0, 1'b1};
        vecs[3] = '{24'h008000, 24'h000000, 16, 32, 16'hFFFF, EXP3, 1, 1'b1};
        vecs[4] = '{24'h007FFF, 24'h007FFF, 16, 32, 16'h0000, EXP4, 1, 1'b1};

        repeat (3) @(negedge Clk);
        checkOutput("reset Sample_out", 32'(Sample_out), 32'h0);
        checkOutput("reset Sample_valid", 32'(Sample_valid), 32'h0);
        checkOutput("reset AUD_DACDAT", 32'(AUD_DACDAT), 32'h0);
        checkOutput("reset Frame_err", 32'(Frame_err), 32'h0);
        Reset_n = 1'b1;

        applyStimulus(1'b1, 24'h0, 16, 32, 1'b0);

        for (int k = 0; k < 5; k++) begin
            Sample_in = vecs[k].sin;
            v0 = validCount;
            applyStimulus(1'b0, vecs[k].left, vecs[k].nbits, vecs[k].leftPeriods, 1'b1);
            checkOutput($sformatf("vec%0d valid after left", k),
                        32'(validCount - v0), 32'(vecs[k].expValid * LEFT_VALID));
            if (vecs[k].leftPeriods >= 18) begin
                readDac(dacWord, tailZero, 32);
                checkOutput($sformatf("vec%0d left DAC word", k), 32'(dacWord), 32'(vecs[k].sin));
                checkOutput($sformatf("vec%0d left DAC zeros", k), 32'(tailZero), 32'h1);
            end
            applyStimulus(1'b1, vecs[k].right, vecs[k].nbits, 32, 1'b0);
            readDac(dacWord, tailZero, 32);
            checkOutput($sformatf("vec%0d right DAC word", k), 32'(dacWord), 32'(vecs[k].sin));
            checkOutput($sformatf("vec%0d right DAC zeros", k), 32'(tailZero), 32'h1);
            checkOutput($sformatf("vec%0d valid per frame", k),
                        32'(validCount - v0), 32'(vecs[k].expValid));
            checkOutput($sformatf("vec%0d Sample_out", k), 32'(Sample_out), 32'(vecs[k].expOut));
            checkOutput($sformatf("vec%0d Frame_err", k), 32'(Frame_err), 32'(vecs[k].expErr));
        end

        // Reset asserted partway through a left word, away from any Clk edge.
        Sample_in = 16'hFFFF;
        applyStimulus(1'b0, 24'h00FFFF, 16, 8, 1'b0);
        #3 Reset_n = 1'b0;
        #1;
        checkOutput("midreset Sample_out", 32'(Sample_out), 32'h0);
        checkOutput("midreset Sample_valid", 32'(Sample_valid), 32'h0);
        checkOutput("midreset AUD_DACDAT", 32'(AUD_DACDAT), 32'h0);
        checkOutput("midreset Frame_err", 32'(Frame_err), 32'h0);
        @(negedge Clk);
        AUD_BCLK   = 1'b0;
        AUD_LRCK   = 1'b0;
        AUD_ADCDAT = 1'b0;
        repeat (4) @(negedge Clk);
        Reset_n = 1'b1;
        v0 = validCount;
        applyStimulus(1'b1, 24'h0, 16, 32, 1'b0);
        checkOutput("postreset no early valid", 32'(validCount - v0), 32'h0);
        applyStimulus(1'b0, 24'h000F0F, 16, 32, 1'b0);
        applyStimulus(1'b1, 24'h000000, 16, 32, 1'b0);
        checkOutput("postreset valid count", 32'(validCount - v0), 32'h1);
        checkOutput("postreset Sample_out", 32'(Sample_out), 32'(EXPR));
        checkOutput("postreset Frame_err", 32'(Frame_err), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
